// File: rtl/interval_timer_if.sv
// Control/status bundle for interval_timer: the master programs and starts the
// timer, the slave (the timer) reports progress and its FSM state for checkers.
interface interval_timer_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] period;
    logic             periodic;
    logic             start;
    logic             stop;
    logic             pause;
    logic             busy;
    logic             tick;
    logic             expired;
    logic [WIDTH-1:0] count;
    logic [1:0]       state_dbg;

    modport master (
        output period, periodic, start, stop, pause,
        input  busy, tick, expired, count, state_dbg
    );

    modport slave (
        input  period, periodic, start, stop, pause,
        output busy, tick, expired, count, state_dbg
    );
endinterface

// File: rtl/interval_timer.sv
// Runtime-programmable interval timer: one-shot or auto-reload, optional clock
// prescaler, pause/abort/retrigger, one-cycle tick and sticky expired flag.
module interval_timer #(
    parameter int WIDTH    = 16,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              reset,
    interval_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] period_q, period_n;
    logic             periodic_q, periodic_n;
    logic [WIDTH-1:0] count_q, count_n;
    logic             tick_q, tick_n;
    logic             expired_q, expired_n;
    logic             busy_q;
    logic             pre_clr, pre_adv, step;
    logic             start_ok;

    // start is a single-edge request; it is only accepted when period is non-zero,
    // and an accepted start always wins over stop and pause on the same edge.
    assign start_ok = bus.start && (bus.period != '0);

    generate
        if (PRESCALE > 1) begin : g_pre
            localparam int PW = $clog2(PRESCALE);
            logic [PW-1:0] pre;
            assign step = (pre == PW'(PRESCALE - 1));
            always_ff @(posedge clk) begin
                if (reset || pre_clr) begin
                    pre <= '0;
                end else if (pre_adv) begin
                    pre <= step ? '0 : pre + PW'(1);
                end
            end
        end else begin : g_nopre
            logic unused_pre;
            assign unused_pre = pre_clr ^ pre_adv;
            assign step       = 1'b1;
        end
    endgenerate

    always_comb begin
        state_n    = state;
        period_n   = period_q;
        periodic_n = periodic_q;
        count_n    = count_q;
        tick_n     = 1'b0;
        expired_n  = expired_q;
        pre_clr    = 1'b0;
        pre_adv    = 1'b0;
        if (start_ok) begin
            period_n   = bus.period;
            periodic_n = bus.periodic;
            count_n    = '0;
            expired_n  = 1'b0;
            pre_clr    = 1'b1;
            state_n    = S_RUN;
        end else if (bus.stop) begin
            count_n   = '0;
            expired_n = 1'b0;
            pre_clr   = 1'b1;
            state_n   = S_IDLE;
        end else if (state == S_RUN && !bus.pause) begin
            pre_adv = 1'b1;
            if (step) begin
                if (count_q == period_q - WIDTH'(1)) begin
                    tick_n = 1'b1;
                    if (periodic_q) begin
                        count_n = '0;
                    end else begin
                        count_n   = period_q;
                        expired_n = 1'b1;
                        state_n   = S_DONE;
                    end
                end else begin
                    count_n = count_q + WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            period_q   <= '0;
            periodic_q <= 1'b0;
            count_q    <= '0;
            tick_q     <= 1'b0;
            expired_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_n;
            period_q   <= period_n;
            periodic_q <= periodic_n;
            count_q    <= count_n;
            tick_q     <= tick_n;
            expired_q  <= expired_n;
            busy_q     <= (state_n == S_RUN);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.tick      = tick_q;
    assign bus.expired   = expired_q;
    assign bus.count     = count_q;
    assign bus.state_dbg = state;

endmodule
